// File: rtl/bcfg_pkg.sv
// Shared types and sizes for the boot-configuration snapshot engine.
package bcfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bcfg_state_e;

  localparam int NUM_RT_READ_QUADS = 4;
  localparam int NUM_BC_READ_QUADS = NUM_RT_READ_QUADS + 1;
  localparam int SAMPLE_ADDR_W     = 6;
  localparam int DATA_W            = 32;
  localparam int QUAD_W            = 5;

endpackage

// File: rtl/bcfg_sample_ram.sv
// Double-banked snapshot store: address is {bank, quad}, one write port, registered read.
module bcfg_sample_ram
  import bcfg_pkg::*;
#(
  parameter int AW = SAMPLE_ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bcfg_sampler.sv
// Captures timestamp plus NUM_QUADS-1 source quadlets into a shadow bank and
// publishes the whole block atomically by flipping the active bank.
module bcfg_sampler
  import bcfg_pkg::*;
#(
  parameter int          NUM_QUADS = NUM_BC_READ_QUADS,
  parameter logic [15:0] SRC_BASE  = 16'h0000
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     sample_start,
  input  logic [31:0]              timestamp,
  output logic                     sample_busy,
  input  logic [SAMPLE_ADDR_W-1:0] sample_raddr,
  output logic [31:0]              sample_rdata,
  output logic [15:0]              src_raddr,
  output logic                     src_ren,
  input  logic [31:0]              src_rdata,
  output logic [7:0]               overrun_cnt
);

  localparam logic [5:0] LAST_K = 6'(NUM_QUADS - 1);
  localparam logic [6:0] NQ_LIM = 7'(NUM_QUADS);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  bcfg_state_e        state_q;
  logic [5:0]         k_q;
  logic               busy_q;
  logic               ren_q;
  logic [15:0]        raddr_q;
  logic               rd_vld_q;
  logic [QUAD_W-1:0]  rd_idx_q;
  logic               bank_q;
  logic               snap_valid_q;
  logic [7:0]         ovr_q;
  logic               gate_q;

  logic               start_acc;
  logic               ram_we;
  logic [SAMPLE_ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;

  assign start_acc = sample_start && !reset && (state_q == IDLE);

  // Shadow-bank write: returning source data has priority; the timestamp
  // lands in quad 0 on the accept cycle, when no fetch can be in flight.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {~bank_q, 5'd0};
    ram_wdata = timestamp;
    if (rd_vld_q && !reset) begin
      ram_we    = 1'b1;
      ram_waddr = {~bank_q, rd_idx_q};
      ram_wdata = src_rdata;
    end else if (start_acc) begin
      ram_we    = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      busy_q       <= 1'b0;
      ren_q        <= 1'b0;
      raddr_q      <= '0;
      rd_vld_q     <= 1'b0;
      rd_idx_q     <= '0;
      bank_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      ovr_q        <= '0;
    end else begin
      rd_vld_q <= ren_q;
      rd_idx_q <= k_q[QUAD_W-1:0];
      if (sample_start && (state_q != IDLE)) begin
        ovr_q <= sat_inc(ovr_q);
      end
      case (state_q)
        IDLE: begin
          if (sample_start) begin
            busy_q <= 1'b1;
            k_q    <= 6'd1;
            if (NUM_QUADS > 1) begin
              state_q <= FETCH;
              ren_q   <= 1'b1;
              raddr_q <= SRC_BASE;
            end else begin
              state_q <= DONE;
            end
          end
        end
        FETCH: begin
          if (k_q == LAST_K) begin
            state_q <= DRAIN;
            ren_q   <= 1'b0;
          end else begin
            k_q     <= k_q + 6'd1;
            raddr_q <= raddr_q + 16'd1;
          end
        end
        DRAIN: state_q <= DONE;
        DONE: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          bank_q       <= ~bank_q;
          snap_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read gate travels with the registered RAM read so both refer to the same address.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      gate_q <= 1'b0;
    end else begin
      gate_q <= snap_valid_q && ({1'b0, sample_raddr} < NQ_LIM);
    end
  end

  bcfg_sample_ram #(
    .AW (SAMPLE_ADDR_W),
    .DW (DATA_W)
  ) u_ram (
    .clk_i   (sysclk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i ({bank_q, sample_raddr[QUAD_W-1:0]}),
    .rdata_o (ram_rdata)
  );

  assign sample_rdata = gate_q ? ram_rdata : '0;
  assign sample_busy  = busy_q;
  assign src_ren      = ren_q;
  assign src_raddr    = raddr_q;
  assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_bcfg_sampler.sv
// Self-checking bench for bcfg_sampler: three instances (NUM_QUADS 5, 1, and 5 with wrapping base).
module tb_bcfg_sampler;

  localparam int          NQ    = 5;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam logic [15:0] WBASE = 16'hFFFE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] timestamp = '0;
  logic [31:0] pat = '0;

  logic m_start = 0, o_start = 0, w_start = 0;
  logic [5:0] m_raddr = '0, o_raddr = '0, w_raddr = '0;
  logic m_busy, o_busy, w_busy;
  logic [31:0] m_rdata, o_rdata, w_rdata;
  logic [15:0] m_src_raddr, o_src_raddr, w_src_raddr;
  logic m_src_ren, o_src_ren, w_src_ren;
  logic [31:0] m_src_rdata = '0, o_src_rdata = '0, w_src_rdata = '0;
  logic [7:0] m_ovr, o_ovr, w_ovr;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_snap [NQ];

  always #5 clk = ~clk;

  // Source memory: data = pat + address, valid one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    m_src_rdata <= m_src_ren ? pat + {16'h0, m_src_raddr} : $urandom;
    o_src_rdata <= o_src_ren ? pat + {16'h0, o_src_raddr} : $urandom;
    w_src_rdata <= w_src_ren ? pat + {16'h0, w_src_raddr} : $urandom;
  end

  bcfg_sampler #(.NUM_QUADS(NQ), .SRC_BASE(BASE)) u_dut (
    .sysclk(clk), .reset(reset), .sample_start(m_start), .timestamp(timestamp),
    .sample_busy(m_busy), .sample_raddr(m_raddr), .sample_rdata(m_rdata),
    .src_raddr(m_src_raddr), .src_ren(m_src_ren), .src_rdata(m_src_rdata),
    .overrun_cnt(m_ovr));

  bcfg_sampler #(.NUM_QUADS(1), .SRC_BASE(BASE)) u_one (
    .sysclk(clk), .reset(reset), .sample_start(o_start), .timestamp(timestamp),
    .sample_busy(o_busy), .sample_raddr(o_raddr), .sample_rdata(o_rdata),
    .src_raddr(o_src_raddr), .src_ren(o_src_ren), .src_rdata(o_src_rdata),
    .overrun_cnt(o_ovr));

  bcfg_sampler #(.NUM_QUADS(NQ), .SRC_BASE(WBASE)) u_wrap (
    .sysclk(clk), .reset(reset), .sample_start(w_start), .timestamp(timestamp),
    .sample_busy(w_busy), .sample_raddr(w_raddr), .sample_rdata(w_rdata),
    .src_raddr(w_src_raddr), .src_ren(w_src_ren), .src_rdata(w_src_rdata),
    .overrun_cnt(w_ovr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model(input logic [31:0] ts, input logic [31:0] p);
    for (int q = 0; q < NQ; q++)
      exp_snap[q] = (q == 0) ? ts : p + 32'(BASE) + 32'(q - 1);
  endtask

  task automatic test_reset();
    reset = 1; m_start = 1;
    repeat (3) tick();
    reset = 0; m_start = 0;
    n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", m_busy); end
    n_cmp++; if (m_src_ren !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %0b want 0", m_src_ren); end
    n_cmp++; if (m_src_raddr !== 16'h0) begin n_err++; $display("FAIL reset_raddr: got %h want 0000", m_src_raddr); end
    n_cmp++; if (m_ovr !== 8'h0) begin n_err++; $display("FAIL reset_ovr: got %0d want 0", m_ovr); end
    n_cmp++; if (m_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
    n_cmp++; if (o_busy !== 1'b0 || w_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_others: got %0b%0b want 00", o_busy, w_busy); end
    for (int q = 0; q < NQ; q++) begin
      m_raddr = 6'(q); tick();
      n_cmp++; if (m_rdata !== 32'h0) begin n_err++; $display("FAIL reset_read q%0d: got %h want 0", q, m_rdata); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] ts;
    logic exp_busy, exp_ren;
    logic [15:0] exp_addr;
    ts = 32'h0000_1234;
    pat = 32'hA000_0000;
    timestamp = ts; m_start = 1; tick(); m_start = 0; timestamp = $urandom;
    for (int i = 1; i <= NQ + 2; i++) begin
      exp_busy = (i <= NQ + 1);
      exp_ren  = (i <= NQ - 1);
      exp_addr = BASE + 16'(i - 1);
      n_cmp++; if (m_busy !== exp_busy) begin n_err++; $display("FAIL basic_busy T+%0d: got %0b want %0b", i, m_busy, exp_busy); end
      n_cmp++; if (m_src_ren !== exp_ren) begin n_err++; $display("FAIL basic_ren T+%0d: got %0b want %0b", i, m_src_ren, exp_ren); end
      if (exp_ren) begin
        n_cmp++; if (m_src_raddr !== exp_addr) begin n_err++; $display("FAIL basic_addr T+%0d: got %h want %h", i, m_src_raddr, exp_addr); end
      end
      tick();
    end
    set_model(ts, pat);
    for (int q = 0; q < NQ; q++) begin
      m_raddr = 6'(q); tick();
      n_cmp++; if (m_rdata !== exp_snap[q]) begin n_err++; $display("FAIL basic_read q%0d: got %h want %h", q, m_rdata, exp_snap[q]); end
    end
    m_raddr = 6'd5; tick();
    n_cmp++; if (m_rdata !== 32'h0) begin n_err++; $display("FAIL bound_raddr5: got %h want 0", m_rdata); end
    m_raddr = 6'd63; tick();
    n_cmp++; if (m_rdata !== 32'h0) begin n_err++; $display("FAIL bound_raddr63: got %h want 0", m_rdata); end
  endtask

  task automatic test_coherency();
    logic [31:0] old_v, new_v, ts, ex;
    m_raddr = 6'd2; tick(); tick();
    old_v = exp_snap[2];
    pat = pat ^ ({$urandom} | 32'h1000_0000);
    ts = $urandom;
    new_v = pat + 32'(BASE) + 32'd1;
    timestamp = ts; m_start = 1; tick(); m_start = 0; timestamp = $urandom;
    for (int j = 1; j <= NQ + 5; j++) begin
      ex = (j >= NQ + 3) ? new_v : old_v;
      n_cmp++; if (m_rdata !== ex) begin n_err++; $display("FAIL coher T+%0d: got %h want %h", j, m_rdata, ex); end
      tick();
    end
    set_model(ts, pat);
    for (int q = 0; q < NQ; q++) begin
      m_raddr = 6'(q); tick();
      n_cmp++; if (m_rdata !== exp_snap[q]) begin n_err++; $display("FAIL coher_read q%0d: got %h want %h", q, m_rdata, exp_snap[q]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ts1, ts2;
    logic exp_busy, exp_ren;
    ts1 = $urandom; ts2 = $urandom;
    pat = $urandom;
    timestamp = ts1; m_start = 1; tick(); m_start = 0;
    for (int i = 1; i <= NQ + 1; i++) begin
      n_cmp++; if (m_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy1 T+%0d: got %0b want 1", i, m_busy); end
      tick();
    end
    n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %0b want 0", m_busy); end
    pat = $urandom;
    timestamp = ts2; m_start = 1; tick(); m_start = 0; timestamp = $urandom;
    for (int i = 1; i <= NQ + 2; i++) begin
      exp_busy = (i <= NQ + 1);
      exp_ren  = (i <= NQ - 1);
      n_cmp++; if (m_busy !== exp_busy) begin n_err++; $display("FAIL b2b_busy2 T+%0d: got %0b want %0b", i, m_busy, exp_busy); end
      n_cmp++; if (m_src_ren !== exp_ren) begin n_err++; $display("FAIL b2b_ren T+%0d: got %0b want %0b", i, m_src_ren, exp_ren); end
      tick();
    end
    n_cmp++; if (m_ovr !== 8'd0) begin n_err++; $display("FAIL b2b_ovr: got %0d want 0", m_ovr); end
    set_model(ts2, pat);
    for (int q = 0; q < NQ; q++) begin
      m_raddr = 6'(q); tick();
      n_cmp++; if (m_rdata !== exp_snap[q]) begin n_err++; $display("FAIL b2b_read q%0d: got %h want %h", q, m_rdata, exp_snap[q]); end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] ts;
    logic exp_busy;
    int ovr_m, last_acc;
    ts = $urandom; pat = $urandom;
    timestamp = ts; m_start = 1; tick();
    for (int i = 1; i <= NQ + 2; i++) begin
      m_start = (i == 1 || i == 3 || i == 5);
      n_cmp++; if (m_busy !== (i <= NQ + 1)) begin n_err++; $display("FAIL ovr_busy T+%0d: got %0b", i, m_busy); end
      tick();
    end
    m_start = 0;
    n_cmp++; if (m_ovr !== 8'd3) begin n_err++; $display("FAIL ovr_three: got %0d want 3", m_ovr); end
    set_model(ts, pat);
    for (int q = 0; q < NQ; q++) begin
      m_raddr = 6'(q); tick();
      n_cmp++; if (m_rdata !== exp_snap[q]) begin n_err++; $display("FAIL ovr_read q%0d: got %h want %h", q, m_rdata, exp_snap[q]); end
    end
    // Random start traffic; the model accepts a start only once the previous busy window has closed.
    ovr_m = 3; last_acc = -100;
    for (int n = 0; n < 500; n++) begin
      exp_busy = (n >= last_acc + 1) && (n <= last_acc + NQ + 1);
      n_cmp++; if (m_busy !== exp_busy) begin n_err++; $display("FAIL sat_busy n%0d: got %0b want %0b", n, m_busy, exp_busy); end
      if (n % 25 == 0) begin
        n_cmp++; if (m_ovr !== 8'(ovr_m)) begin n_err++; $display("FAIL sat_cnt n%0d: got %0d want %0d", n, m_ovr, ovr_m); end
      end
      m_start = ($urandom_range(3) != 0);
      if (m_start) begin
        if (n >= last_acc + NQ + 2) last_acc = n;
        else if (ovr_m < 255) ovr_m++;
      end
      tick();
    end
    m_start = 0;
    repeat (NQ + 3) tick();
    n_cmp++; if (m_ovr !== 8'd255) begin n_err++; $display("FAIL sat_final: got %0d want 255", m_ovr); end
    for (int q = 0; q < NQ; q++) begin
      m_raddr = 6'(q); tick();
      n_cmp++; if (m_rdata !== exp_snap[q]) begin n_err++; $display("FAIL sat_read q%0d: got %h want %h", q, m_rdata, exp_snap[q]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ts;
    pat = $urandom;
    timestamp = $urandom; m_start = 1; tick(); m_start = 0;
    tick();
    reset = 1; tick(); reset = 0;
    n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %0b want 0", m_busy); end
    n_cmp++; if (m_src_ren !== 1'b0) begin n_err++; $display("FAIL rmid_ren: got %0b want 0", m_src_ren); end
    n_cmp++; if (m_src_raddr !== 16'h0) begin n_err++; $display("FAIL rmid_raddr: got %h want 0000", m_src_raddr); end
    n_cmp++; if (m_ovr !== 8'd0) begin n_err++; $display("FAIL rmid_ovr: got %0d want 0", m_ovr); end
    for (int q = 0; q <= NQ; q++) begin
      m_raddr = (q == NQ) ? 6'd63 : 6'(q); tick();
      n_cmp++; if (m_rdata !== 32'h0) begin n_err++; $display("FAIL rmid_read q%0d: got %h want 0", q, m_rdata); end
    end
    ts = $urandom; pat = $urandom;
    timestamp = ts; m_start = 1; tick(); m_start = 0;
    repeat (NQ + 2) tick();
    set_model(ts, pat);
    for (int q = 0; q < NQ; q++) begin
      m_raddr = 6'(q); tick();
      n_cmp++; if (m_rdata !== exp_snap[q]) begin n_err++; $display("FAIL rmid_new q%0d: got %h want %h", q, m_rdata, exp_snap[q]); end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] ts, ex;
    logic [15:0] wexp [4];
    logic exp_ren;
    wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
    ts = $urandom; pat = $urandom;
    timestamp = ts; o_start = 1; tick(); o_start = 0; timestamp = $urandom;
    for (int i = 1; i <= 3; i++) begin
      n_cmp++; if (o_busy !== (i == 1)) begin n_err++; $display("FAIL one_busy T+%0d: got %0b want %0b", i, o_busy, (i == 1)); end
      n_cmp++; if (o_src_ren !== 1'b0) begin n_err++; $display("FAIL one_ren T+%0d: got %0b want 0", i, o_src_ren); end
      tick();
    end
    o_raddr = 6'd0; tick();
    n_cmp++; if (o_rdata !== ts) begin n_err++; $display("FAIL one_q0: got %h want %h", o_rdata, ts); end
    o_raddr = 6'd1; tick();
    n_cmp++; if (o_rdata !== 32'h0) begin n_err++; $display("FAIL one_q1: got %h want 0", o_rdata); end

    ts = $urandom;
    timestamp = ts; w_start = 1; tick(); w_start = 0; timestamp = $urandom;
    for (int i = 1; i <= NQ + 2; i++) begin
      exp_ren = (i <= NQ - 1);
      n_cmp++; if (w_src_ren !== exp_ren) begin n_err++; $display("FAIL wrap_ren T+%0d: got %0b want %0b", i, w_src_ren, exp_ren); end
      if (exp_ren) begin
        n_cmp++; if (w_src_raddr !== wexp[i-1]) begin n_err++; $display("FAIL wrap_addr T+%0d: got %h want %h", i, w_src_raddr, wexp[i-1]); end
      end
      tick();
    end
    for (int q = 0; q < NQ; q++) begin
      ex = (q == 0) ? ts : pat + {16'h0, wexp[q-1]};
      w_raddr = 6'(q); tick();
      n_cmp++; if (w_rdata !== ex) begin n_err++; $display("FAIL wrap_read q%0d: got %h want %h", q, w_rdata, ex); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_coherency();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_boundaries();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
